// File: rtl/display_7seg_multiplexado.sv
// rtl/display_7seg_multiplexado.sv - 4-digit common-anode 7-segment scanner with double-buffered digits
// Ghost blanking at slot start, optional leading-zero suppression, frame-end pulse.
module display_7seg_multiplexado #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] Millares,
   input  logic [3:0] Centenas,
   input  logic [3:0] Decenas,
   input  logic [3:0] Unidades,
   input  logic       dato_valido,
   input  logic       blank_ceros,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       fin_trama
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [31:0] BLANK_U = BLANK_CYC;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   pend_q, pend_d;
   logic          pend_flag_q, pend_flag_d;
   logic [15:0]   disp_q, disp_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          fin_q, fin_d;

   logic          last_slot, frame_end, in_blank, digit_blank;
   logic          m_z, c_z, d_z;
   logic [3:0]    digit;
   logic [31:0]   cnt_ext;

   function automatic logic [6:0] enc7(input logic [3:0] d);
      case (d)
         4'd0:    enc7 = 7'b1000000;
         4'd1:    enc7 = 7'b1111001;
         4'd2:    enc7 = 7'b0100100;
         4'd3:    enc7 = 7'b0110000;
         4'd4:    enc7 = 7'b0011001;
         4'd5:    enc7 = 7'b0010010;
         4'd6:    enc7 = 7'b0000010;
         4'd7:    enc7 = 7'b1111000;
         4'd8:    enc7 = 7'b0000000;
         4'd9:    enc7 = 7'b0010000;
         default: enc7 = 7'b0111111;
      endcase
   endfunction

   always_comb begin
      last_slot = (cnt_q == CNT_MAX);
      frame_end = last_slot && (idx_q == 2'd3);
      cnt_d     = last_slot ? '0 : cnt_q + CW'(1);
      idx_d     = last_slot ? idx_q + 2'd1 : idx_q;

      // Commit uses the pre-edge pend, so a coinciding strobe stays pending
      pend_d      = pend_q;
      pend_flag_d = pend_flag_q;
      disp_d      = disp_q;
      if (frame_end && pend_flag_q) begin
         disp_d      = pend_q;
         pend_flag_d = 1'b0;
      end
      if (dato_valido) begin
         pend_d      = {Millares, Centenas, Decenas, Unidades};
         pend_flag_d = 1'b1;
      end
      fin_d = frame_end;

      m_z = (disp_q[15:12] == 4'd0);
      c_z = (disp_q[11:8]  == 4'd0);
      d_z = (disp_q[7:4]   == 4'd0);
      case (idx_q)
         2'd0: begin digit = disp_q[3:0];   digit_blank = 1'b0;              end
         2'd1: begin digit = disp_q[7:4];   digit_blank = m_z & c_z & d_z;   end
         2'd2: begin digit = disp_q[11:8];  digit_blank = m_z & c_z;         end
         default: begin digit = disp_q[15:12]; digit_blank = m_z;           end
      endcase

      cnt_ext  = {{(32-CW){1'b0}}, cnt_q};
      in_blank = (cnt_ext < BLANK_U);

      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      if (!in_blank && !(blank_ceros && digit_blank)) begin
         an_d[idx_q] = 1'b0;
         seg_d       = enc7(digit);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         idx_q       <= 2'd0;
         pend_q      <= 16'd0;
         pend_flag_q <= 1'b0;
         disp_q      <= 16'd0;
         an_q        <= 4'b1111;
         seg_q       <= 7'b1111111;
         fin_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         pend_q      <= pend_d;
         pend_flag_q <= pend_flag_d;
         disp_q      <= disp_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         fin_q       <= fin_d;
      end
   end

   assign an        = an_q;
   assign seg       = seg_q;
   assign fin_trama = fin_q;

endmodule

// File: tb/tb_display_7seg_multiplexado.sv
// tb/tb_display_7seg_multiplexado.sv - directed self-checking bench, REFRESH_DIV=8 BLANK_CYC=2
module tb_display_7seg_multiplexado;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] Millares, Centenas, Decenas, Unidades;
   logic       dato_valido, blank_ceros;
   logic [3:0] an;
   logic [6:0] seg;
   logic       fin_trama;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S4 = 7'b0011001, S5 = 7'b0010010;
   localparam logic [6:0] S2 = 7'b0100100, S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000;
   localparam logic [6:0] DASH = 7'b0111111, OFF = 7'b1111111;

   display_7seg_multiplexado #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .Millares(Millares), .Centenas(Centenas), .Decenas(Decenas), .Unidades(Unidades),
      .dato_valido(dato_valido), .blank_ceros(blank_ceros),
      .an(an), .seg(seg), .fin_trama(fin_trama)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go_to(input int e);
      while (cyc < e) tick();
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_disp(input string tag, input logic [3:0] a, input logic [6:0] s);
      chk({tag, "_an"}, {12'd0, an}, {12'd0, a});
      chk({tag, "_seg"}, {9'd0, seg}, {9'd0, s});
   endtask

   task automatic strobe(input logic [3:0] m, input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
      Millares = m; Centenas = c; Decenas = d; Unidades = u;
      dato_valido = 1'b1;
      tick();
      dato_valido = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; dato_valido = 1'b0; blank_ceros = 1'b0;
      Millares = 4'd0; Centenas = 4'd0; Decenas = 4'd0; Unidades = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_disp("rst", 4'b1111, OFF);
      chk("rst_fin", {15'd0, fin_trama}, 16'd0);
      rst_n = 1'b1;
      cyc = 0;

      // idle scan of disp=0
      go_to(2);  chk_disp("idle_blank", 4'b1111, OFF);
      go_to(3);  chk_disp("idle_u_first", 4'b1110, S0);
      go_to(8);  chk_disp("idle_u_last", 4'b1110, S0);
      go_to(9);  chk_disp("idle_gap", 4'b1111, OFF);
      go_to(11); chk_disp("idle_tens", 4'b1101, S0);
      go_to(31); chk("fin_31", {15'd0, fin_trama}, 16'd0);
      go_to(32); chk("fin_32", {15'd0, fin_trama}, 16'd1);
      go_to(33); chk("fin_33", {15'd0, fin_trama}, 16'd0);

      // 0,9,2,4 captured at edge 34, committed at 64
      strobe(4'd0, 4'd9, 4'd2, 4'd4);
      go_to(35); chk_disp("pre_commit", 4'b1110, S0);
      go_to(63); chk("fin_63", {15'd0, fin_trama}, 16'd0);
      go_to(64); chk("fin_64", {15'd0, fin_trama}, 16'd1);
      go_to(67); chk_disp("d0924_u", 4'b1110, S4);
      go_to(73); chk_disp("d0924_gap0", 4'b1111, OFF);
      go_to(74); chk_disp("d0924_gap1", 4'b1111, OFF);
      go_to(75); chk_disp("d0924_t", 4'b1101, S2);
      go_to(83); chk_disp("d0924_h", 4'b1011, S9);
      go_to(91); chk_disp("d0924_m", 4'b0111, S0);

      // leading zeros
      go_to(99);
      blank_ceros = 1'b1;
      strobe(4'd0, 4'd0, 4'd0, 4'd1);
      go_to(131); chk_disp("lz1_u", 4'b1110, S1);
      go_to(139); chk_disp("lz1_t", 4'b1111, OFF);
      strobe(4'd0, 4'd0, 4'd0, 4'd0);
      go_to(155); chk_disp("lz1_m", 4'b1111, OFF);
      go_to(163); chk_disp("lz0_u", 4'b1110, S0);
      go_to(171); chk_disp("lz0_t", 4'b1111, OFF);
      blank_ceros = 1'b0;
      go_to(179); chk_disp("nolz_h", 4'b1011, S0);
      go_to(187); chk_disp("nolz_m", 4'b0111, S0);

      // strobe mid idx=1: old value held until the frame ends
      go_to(203);
      strobe(4'd1, 4'd0, 4'd2, 4'd4);
      go_to(211); chk_disp("tear_old_h", 4'b1011, S0);
      go_to(224); chk("fin_224", {15'd0, fin_trama}, 16'd1);
      go_to(227); chk_disp("tear_new_u", 4'b1110, S4);
      go_to(251); chk_disp("tear_new_m", 4'b0111, S1);

      // strobe exactly on the boundary edge 288
      go_to(259);
      strobe(4'd0, 4'd0, 4'd0, 4'd7);
      go_to(287);
      strobe(4'd0, 4'd0, 4'd0, 4'd8);
      chk("fin_288", {15'd0, fin_trama}, 16'd1);
      go_to(291); chk_disp("bnd_prev_u", 4'b1110, S7);
      go_to(323); chk_disp("bnd_next_u", 4'b1110, S8);

      // illegal codes
      go_to(329);
      blank_ceros = 1'b1;
      strobe(4'hA, 4'd0, 4'd5, 4'hC);
      go_to(355); chk_disp("ill_u", 4'b1110, DASH);
      go_to(363); chk_disp("ill_t", 4'b1101, S5);
      go_to(371); chk_disp("ill_h", 4'b1011, S0);
      go_to(379); chk_disp("ill_m", 4'b0111, DASH);

      // async reset mid idx=2 with a strobe pending
      go_to(394);
      strobe(4'd3, 4'd3, 4'd3, 4'd3);
      go_to(404); chk_disp("pre_rst_h", 4'b1011, S0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_disp("async_rst", 4'b1111, OFF);
      chk("async_rst_fin", {15'd0, fin_trama}, 16'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      blank_ceros = 1'b0;
      rst_n = 1'b1;
      cyc = 0;
      go_to(2);  chk_disp("post_rst_blank", 4'b1111, OFF);
      go_to(3);  chk_disp("post_rst_u", 4'b1110, S0);
      go_to(32); chk("post_rst_fin", {15'd0, fin_trama}, 16'd1);
      go_to(35); chk_disp("post_rst_discard", 4'b1110, S0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
